// File: rtl/data_break_requester_if.sv
// -----------------------------------------------------------------------------
// data_break_requester_if
//
// Groups every non-clock signal of the data-break requester: the transfer
// set-up controls, the device word streams in both directions, the CPU
// break request/grant pair, the memory address/data/strobe bus and the
// status outputs.
//
// Modports:
//   master - the requester itself (drives data_break, mem_*, dev_wready,
//            dev_rdata/dev_rvalid, to_disk, busy, done, timeout_err)
//   slave  - the environment (peripheral controller, CPU sequencer, memory)
// -----------------------------------------------------------------------------
interface data_break_requester_if;
  // transfer set-up
  logic        start;
  logic        dir;
  logic [11:0] ca_in;
  logic [11:0] wc_in;
  logic [2:0]  field_in;
  // device -> memory stream
  logic [11:0] dev_wdata;
  logic        dev_wvalid;
  logic        dev_wready;
  // memory -> device stream
  logic [11:0] dev_rdata;
  logic        dev_rvalid;
  logic        dev_rready;
  // CPU break handshake
  logic        data_break;
  logic        to_disk;
  logic        break_in_prog;
  // memory bus
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic [11:0] mem_rdata;
  // status
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport master (
    input  start, dir, ca_in, wc_in, field_in,
    input  dev_wdata, dev_wvalid,
    output dev_wready,
    output dev_rdata, dev_rvalid,
    input  dev_rready,
    output data_break, to_disk,
    input  break_in_prog,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output busy, done, timeout_err
  );

  modport slave (
    output start, dir, ca_in, wc_in, field_in,
    output dev_wdata, dev_wvalid,
    input  dev_wready,
    input  dev_rdata, dev_rvalid,
    output dev_rready,
    input  data_break, to_disk,
    output break_in_prog,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  busy, done, timeout_err
  );
endinterface

// File: rtl/data_break_requester.sv
// -----------------------------------------------------------------------------
// data_break_requester
//
// Device-side initiator for the single-cycle data-break (DMA) protocol.
// Holds a current address (CA), a negative word count (WC), a memory field
// and a direction for one transfer, and moves one 12-bit word per break
// cycle between a device word stream and memory. Each word raises
// data_break, waits for the two-cycle break_in_prog grant (B0, B1), makes
// its single memory access in B0 and, for reads, samples data in B1.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   bus.start           one-cycle pulse, loads ca_in/wc_in/field_in/dir
//   bus.dir             1 = memory -> device, 0 = device -> memory
//   bus.ca_in/wc_in     first address / two's-complement word count (0=4096)
//   bus.field_in        memory field, fixed for the transfer
//   bus.dev_w*          device -> memory word handshake
//   bus.dev_r*          memory -> device word handshake
//   bus.data_break      break request to the CPU (registered)
//   bus.break_in_prog   CPU grant, high for exactly two cycles
//   bus.to_disk         registered dir of the current transfer
//   bus.mem_addr        {field, CA}
//   bus.mem_wdata/we    write data / write strobe (B0 only)
//   bus.mem_rdata       read data, valid one cycle after the address
//   bus.busy            transfer active
//   bus.done            one-cycle pulse on normal completion
//   bus.timeout_err     sticky grant-timeout flag, cleared by start/reset
//
// Parameter:
//   GRANT_TIMEOUT       REQ cycles allowed before the transfer aborts
//                       (8-bit counter)
// -----------------------------------------------------------------------------
module data_break_requester #(
  parameter int unsigned GRANT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  data_break_requester_if.master bus
);

  localparam logic [7:0] TMO = 8'(GRANT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    BRK0,
    BRK1,
    DELIV,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [11:0] r_ca;
  logic [11:0] r_wc;
  logic [2:0]  r_field;
  logic        r_dir;
  logic [11:0] r_hold;
  logic [7:0]  r_tcnt;
  logic        r_data_break;
  logic        r_busy;
  logic        r_timeout_err;

  logic        w_accept;
  logic        w_timeout;
  logic [7:0]  w_tcnt_inc;
  logic [11:0] w_ca_inc;
  logic [11:0] w_wc_inc;

  assign w_tcnt_inc = r_tcnt + 8'd1;
  assign w_ca_inc   = r_ca + 12'd1;
  assign w_wc_inc   = r_wc + 12'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = bus.dir ? REQ : LOAD;
        end
      end
      LOAD: begin
        if (bus.dev_wvalid) begin
          w_next = REQ;
        end
      end
      REQ: begin
        // A grant arriving on the last allowed cycle still wins.
        if (bus.break_in_prog) begin
          w_next = BRK0;
        end else if (w_tcnt_inc == TMO) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      BRK0: begin
        w_next = BRK1;
      end
      BRK1: begin
        if (r_dir) begin
          w_next = DELIV;
        end else if (w_wc_inc == '0) begin
          w_next = DONE;
        end else begin
          w_next = LOAD;
        end
      end
      DELIV: begin
        if (bus.dev_rready) begin
          w_next = (r_wc == '0) ? DONE : REQ;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ca          <= '0;
      r_wc          <= '0;
      r_field       <= '0;
      r_dir         <= 1'b0;
      r_hold        <= '0;
      r_tcnt        <= '0;
      r_data_break  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Request and busy follow the state being entered, so both are
      // registered and change on the same edge as the state.
      r_data_break <= (w_next == REQ);
      r_busy       <= (w_next != IDLE);

      if (w_accept) begin
        r_ca          <= bus.ca_in;
        r_wc          <= bus.wc_in;
        r_field       <= bus.field_in;
        r_dir         <= bus.dir;
        r_timeout_err <= 1'b0;
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end

      // The grant wait counter only runs while staying in REQ; every new
      // request starts counting from zero.
      if ((r_state == REQ) && (w_next == REQ)) begin
        r_tcnt <= w_tcnt_inc;
      end else begin
        r_tcnt <= '0;
      end

      if ((r_state == LOAD) && bus.dev_wvalid) begin
        r_hold <= bus.dev_wdata;
      end

      if (r_state == BRK1) begin
        r_ca <= w_ca_inc;
        r_wc <= w_wc_inc;
        if (r_dir) begin
          r_hold <= bus.mem_rdata;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.data_break  = r_data_break;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign bus.to_disk     = r_dir;
  assign bus.mem_addr    = {r_field, r_ca};
  assign bus.mem_wdata   = r_hold;
  assign bus.mem_we      = (r_state == BRK0) && !r_dir;
  assign bus.dev_wready  = (r_state == LOAD);
  assign bus.dev_rvalid  = (r_state == DELIV);
  assign bus.dev_rdata   = r_hold;
  assign bus.done        = (r_state == DONE);

endmodule

// File: tb/tb_data_break_requester.sv
module tb_data_break_requester;

  logic clk;
  logic reset;
  logic cpu_bip;
  logic spur_bip;
  int   cpu_en;
  int   cpu_lat;

  int n_checks;
  int n_pass;
  int n_done;
  int n_writes;
  int n_reads;

  logic [26:0] exp_w[$];
  logic [11:0] exp_r[$];

  data_break_requester_if bus ();

  data_break_requester #(
    .GRANT_TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.break_in_prog = cpu_bip | spur_bip;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read model: fixed contents, data valid one cycle after address.
  function automatic logic [11:0] rom(input logic [14:0] a);
    case (a)
      15'o07777: rom = 12'o0042;
      15'o00000: rom = 12'o0043;
      default:   rom = a[11:0] ^ 12'o5252;
    endcase
  endfunction

  always @(posedge clk) bus.mem_rdata <= rom(bus.mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0o, required %0o", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // CPU sequencer: grants two cycles of break_in_prog cpu_lat cycles after
  // seeing data_break.
  task automatic cpu_model();
    forever begin
      @(negedge clk);
      if (cpu_en != 0 && bus.data_break && !reset) begin
        repeat (cpu_lat) @(negedge clk);
        cpu_bip = 1'b1;
        repeat (2) @(negedge clk);
        cpu_bip = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [26:0] ew;
    logic [11:0] er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.done) n_done++;
        if (bus.mem_we) begin
          n_writes++;
          if (exp_w.size() == 0) begin
            n_checks++;
            $display("FAIL mem_write: got write addr=%0o data=%0o, required none",
                     bus.mem_addr, bus.mem_wdata);
          end else begin
            ew = exp_w.pop_front();
            check("mem_write", {5'b0, bus.mem_addr, bus.mem_wdata}, {5'b0, ew});
          end
        end
        if (bus.dev_rvalid && bus.dev_rready) begin
          n_reads++;
          if (exp_r.size() == 0) begin
            n_checks++;
            $display("FAIL dev_read: got word %0o, required none", bus.dev_rdata);
          end else begin
            er = exp_r.pop_front();
            check("dev_read", {20'b0, bus.dev_rdata}, {20'b0, er});
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic d, input logic [2:0] f,
                          input logic [11:0] ca, input logic [11:0] wc);
    tick();
    bus.start    = 1'b1;
    bus.dir      = d;
    bus.field_in = f;
    bus.ca_in    = ca;
    bus.wc_in    = wc;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic dev_send(input logic [11:0] w);
    bit ok;
    ok = 1'b0;
    bus.dev_wdata  = w;
    bus.dev_wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.dev_wready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("dev_wready_wait", "no wready within 100 cycles");
    tick();
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int d0;
    int w0;
    int r0;
    int cnt;
    bit ok;
    logic [11:0] a;

    n_checks = 0; n_pass = 0; n_done = 0; n_writes = 0; n_reads = 0;
    cpu_bip = 1'b0; spur_bip = 1'b0; cpu_en = 1; cpu_lat = 3;
    reset = 1'b1;
    bus.start = 1'b0; bus.dir = 1'b0; bus.ca_in = '0; bus.wc_in = '0;
    bus.field_in = '0; bus.dev_wdata = '0; bus.dev_wvalid = 1'b0;
    bus.dev_rready = 1'b0;

    fork
      cpu_model();
      monitor();
    join_none

    // ---------------- reset state
    repeat (3) @(negedge clk);
    check("rst_data_break", {31'b0, bus.data_break}, 0);
    check("rst_mem_we", {31'b0, bus.mem_we}, 0);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_timeout_err", {31'b0, bus.timeout_err}, 0);
    check("rst_to_disk", {31'b0, bus.to_disk}, 0);
    check("rst_handshakes", {30'b0, bus.dev_wready, bus.dev_rvalid}, 0);
    check("rst_mem_addr", {17'b0, bus.mem_addr}, 0);
    check("rst_data", {8'b0, bus.mem_wdata, bus.dev_rdata}, 0);
    tick();
    reset = 1'b0;

    // ---------------- write, 3 words, grant latency 3
    exp_w.push_back({15'o20100, 12'o1111});
    exp_w.push_back({15'o20101, 12'o2222});
    exp_w.push_back({15'o20102, 12'o3333});
    d0 = n_done; w0 = n_writes;
    do_start(1'b0, 3'o2, 12'o0100, 12'o7775);
    check("wr_busy", {31'b0, bus.busy}, 1);
    check("wr_to_disk", {31'b0, bus.to_disk}, 0);
    dev_send(12'o1111);
    dev_send(12'o2222);
    dev_send(12'o3333);
    bus.dev_wvalid = 1'b0;
    wait_done("wr_done", 200);
    // start arriving in the DONE cycle is not accepted
    bus.start = 1'b1; bus.dir = 1'b1; bus.field_in = 3'o7;
    bus.ca_in = 12'o7000; bus.wc_in = 12'o7777;
    tick();
    bus.start = 1'b0;
    check("wr_final_addr", {17'b0, bus.mem_addr}, 32'(15'o20103));
    check("start_in_done_busy", {31'b0, bus.busy}, 0);
    tick();
    check("start_in_done_break", {31'b0, bus.data_break}, 0);
    check("wr_done_count", 32'(n_done - d0), 1);
    check("wr_write_count", 32'(n_writes - w0), 3);

    // ---------------- read, 2 words, wrap, rready stall
    exp_r.push_back(12'o0042);
    exp_r.push_back(12'o0043);
    bus.dev_rready = 1'b0;
    do_start(1'b1, 3'o0, 12'o7777, 12'o7776);
    check("rd_to_disk", {31'b0, bus.to_disk}, 1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.dev_rvalid) begin
        ok = 1'b1;
        break;
      end
    end
    check("rd_rvalid_seen", {31'b0, ok}, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("rd_stall_rvalid", {31'b0, bus.dev_rvalid}, 1);
      check("rd_stall_no_req", {31'b0, bus.data_break}, 0);
    end
    tick();
    bus.dev_rready = 1'b1;
    wait_done("rd_done", 200);
    tick();
    check("rd_final_addr", {17'b0, bus.mem_addr}, 32'(15'o00001));
    check("rd_queue_empty", 32'(exp_r.size()), 0);

    // ---------------- grant timeout
    cpu_en = 0;
    d0 = n_done; w0 = n_writes;
    do_start(1'b1, 3'o4, 12'o0500, 12'o7777);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.data_break) cnt++;
      if (cnt > 0 && !bus.busy) break;
    end
    check("to_break_cycles", 32'(cnt), 8);
    check("to_data_break_low", {31'b0, bus.data_break}, 0);
    check("to_timeout_err", {31'b0, bus.timeout_err}, 1);
    check("to_busy", {31'b0, bus.busy}, 0);
    repeat (3) tick();
    check("to_no_done", 32'(n_done - d0), 0);
    check("to_no_write", 32'(n_writes - w0), 0);
    cpu_en = 1;

    // ---------------- spurious grants and start while busy
    spur_bip = 1'b1;
    repeat (2) tick();
    spur_bip = 1'b0;
    tick();
    check("sp_idle_addr", {17'b0, bus.mem_addr}, 32'(15'o40500));
    check("sp_idle_busy", {31'b0, bus.busy}, 0);
    check("sp_sticky_err", {31'b0, bus.timeout_err}, 1);
    exp_w.push_back({15'o54000, 12'o0101});
    exp_w.push_back({15'o54001, 12'o0202});
    w0 = n_writes;
    do_start(1'b0, 3'o5, 12'o4000, 12'o7776);
    tick();
    check("sp_err_cleared", {31'b0, bus.timeout_err}, 0);
    check("sp_load_ready", {31'b0, bus.dev_wready}, 1);
    spur_bip = 1'b1;
    repeat (2) tick();
    spur_bip = 1'b0;
    check("sp_load_stays", {31'b0, bus.dev_wready}, 1);
    check("sp_load_no_req", {31'b0, bus.data_break}, 0);
    do_start(1'b1, 3'o1, 12'o1111, 12'o7777);
    check("sp_busy_dir", {31'b0, bus.to_disk}, 0);
    check("sp_busy_addr", {17'b0, bus.mem_addr}, 32'(15'o54000));
    check("sp_busy_ready", {31'b0, bus.dev_wready}, 1);
    dev_send(12'o0101);
    dev_send(12'o0202);
    bus.dev_wvalid = 1'b0;
    wait_done("sp_done", 200);
    tick();
    check("sp_final_addr", {17'b0, bus.mem_addr}, 32'(15'o54002));
    check("sp_write_count", 32'(n_writes - w0), 2);

    // ---------------- full 4096-word read, zero-wait
    cpu_lat = 0;
    bus.dev_rready = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      a = 12'(12'o1234 + i);
      exp_r.push_back(rom({3'o3, a}));
    end
    r0 = n_reads; d0 = n_done;
    do_start(1'b1, 3'o3, 12'o1234, 12'o0000);
    wait_done("full_done", 20000);
    check("full_read_count", 32'(n_reads - r0), 4096);
    tick();
    check("full_final_addr", {17'b0, bus.mem_addr}, 32'(15'o31234));
    check("full_queue_empty", 32'(exp_r.size()), 0);
    check("full_done_count", 32'(n_done - d0), 1);

    // ---------------- reset during BRK0 of a write
    cpu_lat = 3;
    exp_w.push_back({15'o10200, 12'o1234});
    do_start(1'b0, 3'o1, 12'o0200, 12'o7777);
    dev_send(12'o1234);
    bus.dev_wvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        ok = 1'b1;
        break;
      end
    end
    check("mr_we_seen", {31'b0, ok}, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_mem_we", {31'b0, bus.mem_we}, 0);
    check("mr_data_break", {31'b0, bus.data_break}, 0);
    check("mr_busy", {31'b0, bus.busy}, 0);
    check("mr_mem_addr", {17'b0, bus.mem_addr}, 0);
    check("mr_data", {8'b0, bus.mem_wdata, bus.dev_rdata}, 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("mr_queue_empty", 32'(exp_w.size()), 0);
    exp_w.push_back({15'o10200, 12'o4321});
    w0 = n_writes;
    do_start(1'b0, 3'o1, 12'o0200, 12'o7777);
    dev_send(12'o4321);
    bus.dev_wvalid = 1'b0;
    wait_done("mr_after_done", 200);
    tick();
    check("mr_after_addr", {17'b0, bus.mem_addr}, 32'(15'o10201));
    check("mr_after_writes", 32'(n_writes - w0), 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
